deemph_stereo_sched: RTL and testbench

- Time-multiplexed stereo de-emphasis filter controller.
- Shares one registered multiplier between the left and right channels.
- Sequences the first-order update y <= y + b*(x - y) for each channel after the stereo decoder, at the 32 kHz audio sample rate.
- Selects the coefficient for the 50 µs or 75 µs time constant, and supports a bypass mode. Accepts one L/R pair per valid/ready handshake.

---
 rtl/deemph_stereo_sched.sv | 110 +++++++++++
 tb/tb_deemph_stereo_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/deemph_stereo_sched.sv
// Stereo first-order de-emphasis (y += b*(x-y)) sharing one registered multiplier across L and R.
// Accept-to-out_valid 4 clocks, one pair per 4 clocks; producer held off by in_ready, no output backpressure.
module deemph_stereo_sched #(
  parameter int width      = 16,
  parameter int coef_width = 16,
  parameter int coef_50    = 30458,
  parameter int coef_75    = 22332
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_l,
  input  logic [width-1:0] in_r,
  input  logic             tau_sel,
  input  logic             bypass,
  output logic             out_valid,
  output logic [width-1:0] out_l,
  output logic [width-1:0] out_r
);

  localparam int pw = width + coef_width + 2;
  localparam logic [coef_width-1:0] c50 = coef_width'(coef_50);
  localparam logic [coef_width-1:0] c75 = coef_width'(coef_75);

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, ACC_R} state_t;

  state_t                  state;
  logic signed [width-1:0] x_l, x_r, y_l, y_r;
  logic [coef_width-1:0]   coef;
  logic                    byp;
  logic signed [pw-1:0]    p;

  logic signed [width-1:0] mul_x, mul_y, acc_y, y_new;
  logic signed [width:0]   diff;
  logic signed [pw-1:0]    diff_ext, coef_ext, prod, acc_ext, sum;
  logic                    unused_sum_bits;

  assign in_ready = reset_n && (state == IDLE);
  assign out_l    = y_l;
  assign out_r    = y_r;

  // The multiplier serves left in MUL_L and right in MUL_R; the adder serves left in MUL_R, right in ACC_R.
  always_comb begin
    mul_x = x_r;
    mul_y = y_r;
    acc_y = y_r;
    if (state == MUL_L) begin
      mul_x = x_l;
      mul_y = y_l;
    end
    if (state == MUL_R) begin
      acc_y = y_l;
    end
  end

  assign diff     = {mul_x[width-1], mul_x} - {mul_y[width-1], mul_y};
  assign diff_ext = {{(pw-width-1){diff[width]}}, diff};
  assign coef_ext = {{(pw-coef_width){1'b0}}, coef};
  assign prod     = diff_ext * coef_ext;

  assign acc_ext  = p >>> coef_width;
  assign sum      = {{(pw-width){acc_y[width-1]}}, acc_y} + acc_ext;
  assign y_new    = sum[width-1:0];
  // y stays between old y and x, so the bits above width carry no information
  assign unused_sum_bits = ^sum[pw-1:width];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      x_l       <= '0;
      x_r       <= '0;
      y_l       <= '0;
      y_r       <= '0;
      coef      <= '0;
      byp       <= 1'b0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_l   <= in_l;
            x_r   <= in_r;
            byp   <= bypass;
            coef  <= tau_sel ? c75 : c50;
            state <= MUL_L;
          end
        end
        MUL_L: begin
          p     <= prod;
          state <= MUL_R;
        end
        MUL_R: begin
          p     <= prod;
          y_l   <= byp ? x_l : y_new;
          state <= ACC_R;
        end
        ACC_R: begin
          y_r       <= byp ? x_r : y_new;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deemph_stereo_sched.sv
// Bench for deemph_stereo_sched: directed pairs with literal expectations plus a per-cycle reference model.
module tb_deemph_stereo_sched;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, tau_sel, bypass, out_valid;
  logic signed [15:0] in_l, in_r, out_l, out_r;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vld_cnt = 0;

  int q_due[$];
  int q_l[$];
  int q_r[$];
  int ym_l = 0;
  int ym_r = 0;
  int ready_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  deemph_stereo_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_l      (in_l),
    .in_r      (in_r),
    .tau_sel   (tau_sel),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_l     (out_l),
    .out_r     (out_r)
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // y + floor((x - y) * c / 2^16), computed with exact integer arithmetic
  function automatic int filt(input int y, input int x, input int c);
    longint pr, q;
    pr = longint'(x - y) * longint'(c);
    q  = pr / 64'sd65536;
    if (pr < 0 && (pr % 64'sd65536) != 0) q = q - 1;
    return y + int'(q);
  endfunction

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    int c;
    if (!reset_n) begin
      q_due.delete();
      q_l.delete();
      q_r.delete();
      ym_l = 0;
      ym_r = 0;
      ready_cyc = 0;
      chk("m_rst_ready", int'(in_ready), 0);
      chk("m_rst_valid", int'(out_valid), 0);
      chk("m_rst_out_l", int'(out_l), 0);
      chk("m_rst_out_r", int'(out_r), 0);
    end else begin
      chk("m_in_ready", int'(in_ready), (cyc >= ready_cyc) ? 1 : 0);
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        chk("m_out_valid", int'(out_valid), 1);
        chk("m_out_l", int'(out_l), q_l[0]);
        chk("m_out_r", int'(out_r), q_r[0]);
        q_due.delete(0);
        q_l.delete(0);
        q_r.delete(0);
      end else begin
        chk("m_out_valid", int'(out_valid), 0);
      end
      if (out_valid) vld_cnt++;
      if (in_valid && in_ready) begin
        c = tau_sel ? 22332 : 30458;
        if (bypass) begin
          ym_l = int'(in_l);
          ym_r = int'(in_r);
        end else begin
          ym_l = filt(ym_l, int'(in_l), c);
          ym_r = filt(ym_r, int'(in_r), c);
        end
        q_due.push_back(cyc + 4);
        q_l.push_back(ym_l);
        q_r.push_back(ym_r);
        ready_cyc = cyc + 4;
      end
    end
  end

  // Offer one pair, scramble the controls once it is accepted, then check the result and its latency.
  task automatic send(input int l, input int r, input logic tau, input logic byp,
                      input int el, input int er, input string nm);
    int n;
    in_l = 16'(l);
    in_r = 16'(r);
    tau_sel = tau;
    bypass = byp;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tau_sel = ~tau;
    bypass = ~byp;
    in_l = ~in_l;
    in_r = ~in_r;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_l"}, int'(out_l), el);
    chk({nm, "_r"}, int'(out_r), er);
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, int'(out_valid), 0);
  endtask

  task automatic burst();
    int ls[6] = '{100, -2000, 32767, -32768, 5, 0};
    int rs[6] = '{-100, 3000, -32768, 32767, -7, 1};
    int prev, n, v0;
    prev = 0;
    v0 = vld_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_l = 16'(ls[i]);
      in_r = 16'(rs[i]);
      tau_sel = i[0];
      bypass = (i == 3);
      n = 0;
      while (!in_ready && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk("burst_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      if (i > 0) chk("burst_spacing", cyc - prev, 4);
      prev = cyc;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("burst_strobes", vld_cnt - v0, 6);
  endtask

  initial begin
    reset_n = 1'b1;
    in_valid = 1'b0;
    in_l = '0;
    in_r = '0;
    tau_sel = 1'b0;
    bypass = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", int'(in_ready), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_out_l", int'(out_l), 0);
    chk("reset_out_r", int'(out_r), 0);
    reset_n = 1'b1;
    #1 chk("release_ready", int'(in_ready), 1);

    send(16384, 16384, 1'b0, 1'b0, 7614, 7614, "t50_first");
    send(16384, 16384, 1'b0, 1'b0, 11689, 11689, "t50_second");
    send(0, 0, 1'b0, 1'b1, 0, 0, "bypass_zero_a");
    send(-16384, 16384, 1'b0, 1'b0, -7615, 7614, "floor_asym");
    send(0, 0, 1'b1, 1'b1, 0, 0, "bypass_zero_b");
    send(16384, 16384, 1'b1, 1'b0, 5583, 5583, "t75_first");
    send(-123, 456, 1'b0, 1'b1, -123, 456, "bypass_pass");
    send(-32768, -32768, 1'b1, 1'b1, -32768, -32768, "bypass_min");
    send(32767, 32767, 1'b0, 1'b0, -2311, -2311, "extreme");

    burst();

    // Abort a pair while it sits in MUL_R.
    in_l = 16'sd1000;
    in_r = -16'sd1000;
    tau_sel = 1'b0;
    bypass = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_ready", int'(in_ready), 0);
    chk("abort_out_l", int'(out_l), 0);
    chk("abort_out_r", int'(out_r), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", int'(out_valid), 0);
    end
    reset_n = 1'b1;
    #1 chk("abort_release_ready", int'(in_ready), 1);

    send(16384, 16384, 1'b0, 1'b0, 7614, 7614, "after_abort");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
